// File: rtl/bdi_cache_array.sv
// N-way set-associative tag/data array for BDI-compressed lines with a registered lookup,
// per-set round-robin victims and a sequential flush. Optional counters: BDI_CACHE_ARRAY_STATS_EN.
module bdi_cache_array #(
    parameter int TAG_FIELD      = 19,
    parameter int DATA_FIELD     = 256,
    parameter int WAYS           = 8,
    parameter int SETS           = 128,
    parameter int SEGMENTS       = 2,
    parameter int WORDS_PER_LINE = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [$clog2(SETS)-1:0]           req_index,
    input  logic [TAG_FIELD-1:0]              req_tag,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] req_word_addr,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_hit,
    output logic [$clog2(WAYS)-1:0]           rsp_way,
    output logic [$clog2(WAYS*SETS)-1:0]      rsp_line_index,
    output logic [DATA_FIELD-1:0]             rsp_line,
    input  logic                              fill_valid,
    output logic                              fill_ready,
    input  logic [$clog2(SETS)-1:0]           fill_index,
    input  logic [TAG_FIELD-1:0]              fill_tag,
    input  logic [SEGMENTS-1:0]               fill_seg_valid,
    input  logic [DATA_FIELD-1:0]             fill_data,
    input  logic                              fill_way_force,
    input  logic [$clog2(WAYS)-1:0]           fill_way,
    input  logic                              flush_start,
    output logic                              flush_busy,
    output logic                              flush_done
`ifdef BDI_CACHE_ARRAY_STATS_EN
    ,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count
`endif
);

    localparam int IDX_W         = $clog2(SETS);
    localparam int WAY_W         = $clog2(WAYS);
    localparam int LI_W          = $clog2(WAYS * SETS);
    localparam int SEG_W         = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam int WORDS_PER_SEG = WORDS_PER_LINE / SEGMENTS;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DONE} flush_state_e;

    logic [TAG_FIELD-1:0]  tag_mem   [WAYS][SETS];
    logic [DATA_FIELD-1:0] data_mem  [WAYS][SETS];
    logic [SEGMENTS-1:0]   seg_valid [WAYS][SETS];
    logic [WAY_W-1:0]      rr_ptr    [SETS];

    flush_state_e     state_q, state_d;
    logic [IDX_W-1:0] flush_cnt, flush_cnt_d;

    logic [SEG_W-1:0] word_seg;
    logic             look_hit, look_vic_found;
    logic [WAY_W-1:0] look_hit_way, look_vic, look_way;
    logic             fill_vic_found, fill_fire;
    logic [WAY_W-1:0] fill_vic, fill_target;
    logic             req_fire;

    assign word_seg   = SEG_W'(32'(req_word_addr) / WORDS_PER_SEG);
    assign req_ready  = !flush_busy && (!rsp_valid || rsp_ready);
    assign req_fire   = req_valid && req_ready;
    assign fill_ready = !flush_busy;
    assign fill_fire  = fill_valid && fill_ready;

    // Lookup: lowest matching valid way wins; on a miss the first empty way, else the RR pointer.
    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        look_hit       = 1'b0;
        look_hit_way   = '0;
        look_vic_found = 1'b0;
        look_vic       = rr_ptr[req_index];
        for (int w = 0; w < WAYS; w++) begin
            if (!look_hit && seg_valid[w][req_index][word_seg] &&
                tag_mem[w][req_index] == req_tag) begin
                look_hit     = 1'b1;
                look_hit_way = WAY_W'(w);
            end
            if (!look_vic_found && seg_valid[w][req_index] == '0) begin
                look_vic_found = 1'b1;
                look_vic       = WAY_W'(w);
            end
        end
        look_way = look_hit ? look_hit_way : look_vic;
    end

    always_comb begin
        fill_vic_found = 1'b0;
        fill_vic       = rr_ptr[fill_index];
        for (int w = 0; w < WAYS; w++) begin
            if (!fill_vic_found && seg_valid[w][fill_index] == '0) begin
                fill_vic_found = 1'b1;
                fill_vic       = WAY_W'(w);
            end
        end
        fill_target = fill_way_force ? fill_way : fill_vic;
    end

    // NOTE: tag and data are plain storage with no reset; the segment-valid bits alone give them meaning.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            tag_mem[fill_target][fill_index]  <= fill_tag;
            data_mem[fill_target][fill_index] <= fill_data;
        end
    end

    // Fills cannot coincide with flush sweeps because fill_ready is low while flushing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    seg_valid[w][s] <= '0;
            for (int s = 0; s < SETS; s++)
                rr_ptr[s] <= '0;
        end else if (state_q == ST_FLUSH) begin
            for (int w = 0; w < WAYS; w++)
                seg_valid[w][flush_cnt] <= '0;
            rr_ptr[flush_cnt] <= '0;
        end else if (fill_fire) begin
            seg_valid[fill_target][fill_index] <= fill_seg_valid;
            if (!fill_way_force && !fill_vic_found)
                rr_ptr[fill_index] <= rr_ptr[fill_index] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_way        <= '0;
            rsp_line_index <= '0;
            rsp_line       <= '0;
        end else if (req_fire) begin
            rsp_valid      <= 1'b1;
            rsp_hit        <= look_hit;
            rsp_way        <= look_way;
            rsp_line_index <= LI_W'({look_way, req_index});
            rsp_line       <= look_hit ? data_mem[look_hit_way][req_index] : '0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            state_q   <= state_d;
            flush_cnt <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt;
        flush_busy  = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_start) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                flush_busy = 1'b1;
                if (flush_cnt == IDX_W'(SETS - 1))
                    state_d = ST_DONE;
                else
                    flush_cnt_d = flush_cnt + IDX_W'(1);
            end
            ST_DONE: begin
                flush_busy = 1'b1;
                flush_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BDI_CACHE_ARRAY_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (flush_done) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            else if (!rsp_hit && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bdi_cache_array.md
Name: bdi_cache_array

Overview:
- Parametrised N-way set-associative tag/data array for BDI-compressed cachelines; generalises the fixed 8-way, 128-set, combinational-lookup array.
- Adds a registered lookup stage with valid/ready handshake, per-set round-robin victim selection, and a sequential flush engine.
- Returns the compressed line and its flat index; decompression and word select stay downstream.

Parameters:
- TAG_FIELD, 19, tag width
- DATA_FIELD, 256, compressed data bits per line
- WAYS, 8, associativity, power of 2, ≥2
- SETS, 128, sets per way, power of 2
- SEGMENTS, 2, per-line segment-valid bits
- WORDS_PER_LINE, 16, decompressed words per line; divisible by SEGMENTS

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when high with req_valid
- req_index  in  $clog2(SETS)  set index
- req_tag  in  TAG_FIELD  tag
- req_word_addr  in  $clog2(WORDS_PER_LINE)  word within line
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_hit  out  1  hit
- rsp_way  out  $clog2(WAYS)  hit way, else victim way
- rsp_line_index  out  $clog2(WAYS*SETS)  way*SETS+set
- rsp_line  out  DATA_FIELD  compressed data of hit line, 0 on miss
- fill_valid  in  1  line write
- fill_ready  out  1  equals !flush_busy
- fill_index  in  $clog2(SETS)  set
- fill_tag  in  TAG_FIELD  tag
- fill_seg_valid  in  SEGMENTS  segment-valid bits written
- fill_data  in  DATA_FIELD  compressed line
- fill_way_force  in  1  use fill_way instead of victim
- fill_way  in  $clog2(WAYS)  forced way
- flush_start  in  1  start full invalidate
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at flush end

Behaviour:
- Reset (rst low, async): all segment-valid bits, RR pointers, and FSM cleared; outputs 0. Data and tags not reset.
- Segment of request: seg = req_word_addr / (WORDS_PER_LINE/SEGMENTS).
- Hit: lowest-numbered way with tag == req_tag and seg-valid[seg] == 1.
- Lookup:
  - req_ready = !flush_busy && (!rsp_valid || rsp_ready).
  - Compare is combinational at acceptance; result, way, index, and line are registered.
  - rsp_valid rises the next cycle (latency 1).
  - Response is held stable until rsp_ready; later fills do not alter a held response.
  - Back-to-back accepts are allowed when rsp_ready = 1 (throughput 1/cycle).
- Miss: rsp_way = victim = lowest way with all seg bits 0; otherwise rr_ptr[set].
- Fill:
  - Written at the edge where fill_valid && fill_ready.
  - Target way = fill_way if fill_way_force, else victim of fill_index.
  - Tag, data, and seg bits are replaced entirely.
  - rr_ptr[set] increments (wrap WAYS-1→0) only on a non-forced fill whose victim came from the pointer.
- Same-cycle fill + lookup on the same set: lookup sees pre-fill contents.
- FSM:
  - IDLE: flush_start → FLUSH with cnt = 0.
  - FLUSH: each cycle clears seg bits of all ways of set cnt and clears rr_ptr[cnt]; cnt == SETS-1 → DONE.
  - DONE: flush_done = 1 for one cycle → IDLE.
  - flush_start outside IDLE is ignored.
  - Flush takes SETS+1 cycles from the start edge to the done pulse.
  - flush_busy is high in FLUSH and DONE. A response already held is kept and can still complete.
- Reset mid-flush: returns to IDLE; all valid bits cleared.

Optional Feature:
- Macro: BDI_CACHE_ARRAY_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count (32-bit each).
  - Each counts rsp_valid && rsp_ready handshakes by rsp_hit.
  - Counters saturate at 0xFFFFFFFF, clear on reset, and clear when flush_done pulses.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Fill set 5, tag 0x1A2B3, seg 2'b01, not forced (way 0) → lookup set 5, tag 0x1A2B3, word 3 → next cycle hit = 1, way 0, line_index 5, rsp_line = fill_data. Same lookup with word 9 → miss, rsp_way 1.
- 8 fills to set 7 with distinct tags, then 3 more → victims 0..7, then rr_ptr ways 0, 1, 2; the 9th fill's tag overwrites way 0, so the old way-0 tag misses.
- Lookup accepted with rsp_ready = 0 for 4 cycles while a fill overwrites the same line → held response unchanged; req_ready = 0 throughout.
- Fill and lookup same cycle, same set/tag, line initially invalid → miss; an identical lookup next cycle → hit.
- With SETS = 128, flush_start → flush_busy for 129 cycles, flush_done pulses at cycle 129, req_ready = 0 during the flush, and all prior hits become misses.
- Reset asserted mid-flush at cnt = 40 → FSM is IDLE and flush_busy = 0 immediately. With the stats macro defined, 3 hits and 2 misses → counters read 3 and 2.
